// File: rtl/mult_share_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: sequencer states,
// multiplier timing and the operand width limit of the shared 18x18 unit.
package mult_share_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  // Edges from the multiplier load edge until it raises done.
  localparam int MULT_LOAD_TO_DONE = 17;
  localparam int MULT_OP_W         = 18;
  localparam int MAX_REQ           = 4;

endpackage

// File: rtl/mult_share_arb_rr_pick.sv
// Combinational round-robin priority encoder: starting just after the last
// grant and wrapping modulo NREQ, returns the first active requester.
import mult_share_arb_pkg::*;

module mult_share_arb_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic            valid,
  output logic [1:0]      idx
);

  logic [MAX_REQ-1:0] req_pad;
  logic [2:0]         cand;

  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_pad
    if (gi < NREQ) begin : g_live
      assign req_pad[gi] = req[gi];
    end else begin : g_zero
      assign req_pad[gi] = 1'b0;
    end
  end

  // Walk offsets from farthest to nearest so the nearest active one wins.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = 3'd0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last} + 3'(k);
      if (cand >= 3'(NREQ)) begin
        cand = cand - 3'(NREQ);
      end
      if (req_pad[cand[1:0]]) begin
        valid = 1'b1;
        idx   = cand[1:0];
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sequencer sharing one iterative 18x18 multiplier among NREQ
// requesters. Optional signed operation is enabled by MULT_SHARE_SIGNED_EN.
import mult_share_arb_pkg::*;

module mult_share_arb #(
  parameter int NREQ = 2,
  parameter int W    = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W-1:0]    a_in,
  input  logic [NREQ*W-1:0]    b_in,
  input  logic [NREQ-1:0]      sgn_in,
  output logic [NREQ-1:0]      ack,
  output logic [2*W-1:0]       res,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic [MULT_OP_W-1:0] mul_a,
  output logic [MULT_OP_W-1:0] mul_b,
  input  logic [2*MULT_OP_W-1:0] mul_p,
  input  logic                 mul_done
);

  state_e               state_q, state_d;
  logic [1:0]           grant_id_q, grant_id_d;
  logic [MULT_OP_W-1:0] mul_a_q, mul_a_d;
  logic [MULT_OP_W-1:0] mul_b_q, mul_b_d;
  logic [2*W-1:0]       res_q, res_d;

  logic [W-1:0]         a_arr [MAX_REQ];
  logic [W-1:0]         b_arr [MAX_REQ];
  logic [MAX_REQ-1:0]   sgn_vec;
  logic                 pick_valid;
  logic [1:0]           pick_idx;
  logic [W-1:0]         sel_a, sel_b;
  logic [W-1:0]         mag_a, mag_b;
  logic [2*W-1:0]       prod;
  logic [2*W-1:0]       prod_fixed;
  logic                 unused_bits;

  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
    if (gi < NREQ) begin : g_live
      assign a_arr[gi]   = a_in[gi*W +: W];
      assign b_arr[gi]   = b_in[gi*W +: W];
      assign sgn_vec[gi] = sgn_in[gi];
    end else begin : g_zero
      assign a_arr[gi]   = '0;
      assign b_arr[gi]   = '0;
      assign sgn_vec[gi] = 1'b0;
    end
  end

  mult_share_arb_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req),
    .last  (grant_id_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign sel_a = a_arr[pick_idx];
  assign sel_b = b_arr[pick_idx];
  assign prod  = mul_p[2*W-1:0];

`ifdef MULT_SHARE_SIGNED_EN
  logic neg_q, neg_d;
  logic sign_a, sign_b;

  // Negating -2^(W-1) in W bits leaves the same pattern, which read
  // unsigned is exactly the required magnitude 2^(W-1).
  assign sign_a     = sgn_vec[pick_idx] & sel_a[W-1];
  assign sign_b     = sgn_vec[pick_idx] & sel_b[W-1];
  assign mag_a      = sign_a ? -sel_a : sel_a;
  assign mag_b      = sign_b ? -sel_b : sel_b;
  assign prod_fixed = neg_q ? -prod : prod;

  always_comb begin
    neg_d = neg_q;
    if (state_q == ST_IDLE && pick_valid) begin
      neg_d = sign_a ^ sign_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`else
  assign mag_a      = sel_a;
  assign mag_b      = sel_b;
  assign prod_fixed = prod;
`endif

  assign unused_bits = ^{mul_p, sgn_vec};

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    res_d      = res_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_idx;
          mul_a_d    = MULT_OP_W'(mag_a);
          mul_b_d    = MULT_OP_W'(mag_b);
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_done) begin
          res_d   = prod_fixed;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_id_q <= 2'(NREQ-1);
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      res_q      <= res_d;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
    assign ack[gi] = (state_q == ST_ACK) && (grant_id_q == 2'(gi));
  end

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_id_q;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign res      = res_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a behavioural iterative multiplier
// that restarts on operand change and raises done after a fixed edge count.
import mult_share_arb_pkg::*;

module tb_mult_share_arb;

  localparam int NREQ = 2;
  localparam int W    = 18;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0] sgn_in;
  logic [NREQ-1:0] ack;
  logic [2*W-1:0]  res;
  logic            busy;
  logic [1:0]      grant_id;
  logic [17:0]     mul_a;
  logic [17:0]     mul_b;
  logic [35:0]     mul_p;
  logic            mul_done;

  int nvec = 0;
  int nmis = 0;

  mult_share_arb #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .sgn_in   (sgn_in),
    .ack      (ack),
    .res      (res),
    .busy     (busy),
    .grant_id (grant_id),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_p    (mul_p),
    .mul_done (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Iterative multiplier model.
  logic [35:0] ld_a = '0;
  logic [35:0] ld_b = '0;
  int          cnt  = 0;
  logic        m_done = 1'b1;
  logic [35:0] m_p  = '0;

  always @(posedge clk) begin
    if ({18'd0, mul_a} != ld_a || {18'd0, mul_b} != ld_b) begin
      ld_a   <= {18'd0, mul_a};
      ld_b   <= {18'd0, mul_b};
      cnt    <= MULT_LOAD_TO_DONE;
      m_done <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        m_done <= 1'b1;
        m_p    <= ld_a * ld_b;
      end
    end
  end

  assign mul_p    = m_p;
  assign mul_done = m_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input int idx, input logic [17:0] a,
                       input logic [17:0] b, input logic s,
                       input logic [35:0] exp_res, input int exp_n);
    int n;
    logic [1:0] oh;
    oh = 2'(1 << idx);
    n  = 0;
    a_in[idx*W +: W] = a;
    b_in[idx*W +: W] = b;
    sgn_in[idx] = s;
    req[idx] = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ack == '0 && n < 40);
    check({tag, "_ack"}, 64'(ack), 64'(oh));
    check({tag, "_lat"}, 64'(n), 64'(exp_n));
    check({tag, "_res"}, 64'(res), 64'(exp_res));
    $display("op %s: req%0d a=%0h b=%0h -> ack=%b res=%0h after %0d edges",
             tag, idx, a, b, ack, res, n);
    req[idx] = 1'b0;
    sgn_in[idx] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_ack"}, 64'(ack), 64'd0);
  endtask

  initial begin
    int n;
    logic [35:0] exp_c [2];
    logic [35:0] exp_s;

    reset  = 1'b1;
    req    = '0;
    a_in   = '0;
    b_in   = '0;
    sgn_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_grant", 64'(grant_id), 64'(NREQ-1));
    $display("reset: ack=%b busy=%b grant_id=%0d", ack, busy, grant_id);

    do_op("single", 0, 18'd3, 18'd5, 1'b0, 36'd15, 20);
    do_op("repeat", 1, 18'd3, 18'd5, 1'b0, 36'd15, 3);

    // Contention: both requesters continuously active.
    exp_c[0] = 36'd24;
    exp_c[1] = 36'd63;
    a_in[0*W +: W] = 18'd4;
    b_in[0*W +: W] = 18'd6;
    a_in[1*W +: W] = 18'd7;
    b_in[1*W +: W] = 18'd9;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int e;
      logic [1:0] oh;
      e  = k % 2;
      oh = 2'(1 << e);
      n  = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (ack == '0 && n < 40);
      check("cont_ack", 64'(ack), 64'(oh));
      check("cont_res", 64'(res), 64'(exp_c[e]));
      check("cont_grant", 64'(grant_id), 64'(e));
      $display("contention %0d: ack=%b res=%0h grant_id=%0d", k, ack, res, grant_id);
      if (k < 3) begin
        req[e] = 1'b0;
        @(posedge clk);
        #1;
        req[e] = 1'b1;
      end else begin
        req = '0;
      end
    end
    @(posedge clk);
    #1;
    check("cont_busy", 64'(busy), 64'd0);

    do_op("max", 0, 18'h3FFFF, 18'h3FFFF, 1'b0, 36'hFFFF80001, 20);

    // Abandon an operation in WAIT with reset.
    a_in[0*W +: W] = 18'd11;
    b_in[0*W +: W] = 18'd13;
    req[0] = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_busy_grant", 64'(busy), 64'd1);
    check("rstw_grant", 64'(grant_id), 64'd0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("rstw_busy_wait", 64'(busy), 64'd1);
    check("rstw_noack", 64'(ack), 64'd0);
    reset  = 1'b1;
    req    = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rstw_ack", 64'(ack), 64'd0);
    check("rstw_busy", 64'(busy), 64'd0);
    check("rstw_grant_rst", 64'(grant_id), 64'(NREQ-1));
    check("rstw_res", 64'(res), 64'd0);
    check("rstw_mul_a", 64'(mul_a), 64'd0);
    $display("reset in WAIT: ack=%b busy=%b grant_id=%0d", ack, busy, grant_id);

    do_op("after_rst", 1, 18'd2, 18'd7, 1'b0, 36'd14, 20);

`ifdef MULT_SHARE_SIGNED_EN
    exp_s = 36'hFFFFFFFF1;
`else
    exp_s = 36'h13FFF1;
`endif
    do_op("signed", 0, 18'h3FFFD, 18'd5, 1'b1, exp_s, 20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
